cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the single common data bus (CDB) between result producers: the RS ALU, the LSB and the branch unit.
//   Each source pushes {robId, value} into its own 2-entry FIFO. A round-robin scheduler grants one source per cycle.
//   The granted result is broadcast on a registered CDB read by the ROB, RS and LSB.
//   Per-source order is preserved; no result is dropped.
// PARAMETERS
//   NUM_SRC    3  number of result sources (2..8)
//   SRC_WIDTH  2  width of source index, >= clog2(NUM_SRC)
//   ROB_WIDTH  4  ROB index width
// PORTS
//   clockIn    in   1                  clock, single domain
//   resetIn    in   1                  reset, asynchronous, active-high
//   clear      in   1                  flush (misprediction), synchronous
//   srcValid   in   NUM_SRC            per-source push request
//   srcRobId   in   NUM_SRC*ROB_WIDTH  source i at [i*ROB_WIDTH +: ROB_WIDTH]
//   srcVal     in   NUM_SRC*32         source i at [i*32 +: 32]
//   srcReady   out  NUM_SRC            FIFO i can accept (count<2), combinational from state
//   cdbValid   out  1                  broadcast valid, one cycle per result
//   cdbRobId   out  ROB_WIDTH          broadcast ROB index
//   cdbVal     out  32                 broadcast value
//   cdbSrc     out  SRC_WIDTH          index of granted source
//   stallCount out  32                 backpressure cycle counter (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async): all FIFOs empty; cdbValid=0, cdbRobId=0, cdbVal=0, cdbSrc=0, rrPtr=NUM_SRC-1.
//     srcReady reads all-ones, stallCount=0. Outputs change without waiting for a clock edge.
//   - Push: srcValid[i] && srcReady[i] at posedge writes FIFO i. srcValid while !srcReady is ignored; the source must hold.
//   - Per-FIFO: push and pop in the same cycle allowed; count 0..2, 1-bit wrapping read/write ptrs.
//   - Arbitration (comb., each cycle): scan i = rrPtr+1 .. rrPtr+NUM_SRC (mod NUM_SRC); first non-empty FIFO wins.
//   - At posedge, on a grant:
//       pop that FIFO's head; cdbValid<=1, cdbRobId/cdbVal <= head, cdbSrc<=i, rrPtr<=i.
//   - At posedge, no grant: cdbValid<=0, cdbRobId/cdbVal/cdbSrc hold, rrPtr holds.
//   - Latency: result sampled at edge k appears with cdbValid=1 after edge k+1 (minimum 2 edges).
//   - Throughput: 1 result/cycle total. Any non-empty source is granted within NUM_SRC cycles.
//   - clear (priority over push/pop): at posedge, all FIFOs emptied, cdbValid<=0, rrPtr held. Pushes that cycle are dropped.
//   - Mod arithmetic on rrPtr must be explicit compare-and-wrap; NUM_SRC need not be a power of 2.
// CONFIGURATION
//   CDB_STALL_CNT_EN defined:
//     stallCount increments when any srcValid[i] && !srcReady[i] at a posedge.
//     Wraps at 2^32; reset only by resetIn, not by clear.
//   CDB_STALL_CNT_EN undefined: counter logic absent; stallCount tied to 32'b0.
// TESTING
//   1. Assert resetIn with no clock -> cdbValid=0 immediately; after release srcReady=3'b111.
//   2. src0 push robId=5, val=0x1234 at edge k -> after edge k+1: cdbValid=1, robId=5, val=0x1234, cdbSrc=0.
//      After edge k+2: cdbValid=0.
//   3. src0/1/2 push robId 1/2/3 at the same edge -> three consecutive broadcasts: robId 1,2,3 (cdbSrc 0,1,2).
//   4. src0 and src1 stream 4 results each continuously -> CDB alternates 0,1,0,1...
//      All 8 results seen, per-source order kept; srcReady drops only when count=2.
//   5. Two results buffered in FIFO1, assert clear -> no cdbValid afterwards; srcReady=3'b111 next cycle.
//   6. With CDB_STALL_CNT_EN: hold src2 valid while FIFO2 full for 3 edges -> stallCount=3.
//      Without the macro: stallCount stays 0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast signals shared by cdb_arbiter and its producers/consumers.
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 3,
  parameter int SRC_WIDTH = 2,
  parameter int ROB_WIDTH = 4
);
  logic [NUM_SRC-1:0]           srcValid;
  logic [NUM_SRC*ROB_WIDTH-1:0] srcRobId;
  logic [NUM_SRC*32-1:0]        srcVal;
  logic [NUM_SRC-1:0]           srcReady;
  logic                         cdbValid;
  logic [ROB_WIDTH-1:0]         cdbRobId;
  logic [31:0]                  cdbVal;
  logic [SRC_WIDTH-1:0]         cdbSrc;
  logic [31:0]                  stallCount;

  modport master (
    output srcValid, srcRobId, srcVal,
    input  srcReady, cdbValid, cdbRobId, cdbVal, cdbSrc, stallCount
  );

  modport slave (
    input  srcValid, srcRobId, srcVal,
    output srcReady, cdbValid, cdbRobId, cdbVal, cdbSrc, stallCount
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: per-source 2-entry FIFOs feeding a registered broadcast.
// Optional backpressure counter enabled by defining CDB_STALL_CNT_EN.
module cdb_arbiter #(
  parameter int NUM_SRC   = 3,
  parameter int SRC_WIDTH = 2,
  parameter int ROB_WIDTH = 4
) (
  input  logic         clockIn,
  input  logic         resetIn,
  input  logic         clear,
  cdb_arbiter_if.slave bus
);

  localparam int ENTRY_W = ROB_WIDTH + 32;
  localparam logic [SRC_WIDTH-1:0] LAST_SRC = SRC_WIDTH'(NUM_SRC - 1);

  logic [ENTRY_W-1:0]   fifoMem [NUM_SRC][2];
  logic [1:0]           fifoCount [NUM_SRC];
  logic [NUM_SRC-1:0]   rdPtr;
  logic [NUM_SRC-1:0]   wrPtr;
  logic [NUM_SRC-1:0]   notEmpty;
  logic [NUM_SRC-1:0]   pushEn;
  logic [NUM_SRC-1:0]   popEn;
  logic [SRC_WIDTH-1:0] rrPtr;
  logic [SRC_WIDTH-1:0] scanIdx;
  logic [SRC_WIDTH-1:0] grantIdx;
  logic                 grantValid;
  logic [ENTRY_W-1:0]   headData;

  always_comb begin
    bus.srcReady = '0;
    notEmpty     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      bus.srcReady[i] = (fifoCount[i] != 2'd2);
      notEmpty[i]     = (fifoCount[i] != 2'd0);
    end
  end

  assign pushEn = bus.srcValid & bus.srcReady;

  // Scan starts one past the last winner; wrap is an explicit compare so NUM_SRC need not be 2^n.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    scanIdx    = rrPtr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scanIdx = (scanIdx == LAST_SRC) ? '0 : scanIdx + 1'b1;
      if (!grantValid && notEmpty[scanIdx]) begin
        grantValid = 1'b1;
        grantIdx   = scanIdx;
      end
    end
  end

  always_comb begin
    popEn = '0;
    if (grantValid) popEn[grantIdx] = 1'b1;
  end

  assign headData = fifoMem[grantIdx][rdPtr[grantIdx]];

  always_ff @(posedge clockIn) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pushEn[i] && !clear)
        fifoMem[i][wrPtr[i]] <= {bus.srcRobId[i*ROB_WIDTH +: ROB_WIDTH], bus.srcVal[i*32 +: 32]};
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) fifoCount[i] <= 2'd0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      rrPtr        <= LAST_SRC;
      bus.cdbValid <= 1'b0;
      bus.cdbRobId <= '0;
      bus.cdbVal   <= '0;
      bus.cdbSrc   <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) fifoCount[i] <= 2'd0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      bus.cdbValid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (pushEn[i]) wrPtr[i] <= ~wrPtr[i];
        if (popEn[i])  rdPtr[i] <= ~rdPtr[i];
        case ({pushEn[i], popEn[i]})
          2'b10:   fifoCount[i] <= fifoCount[i] + 2'd1;
          2'b01:   fifoCount[i] <= fifoCount[i] - 2'd1;
          default: fifoCount[i] <= fifoCount[i];
        endcase
      end
      if (grantValid) begin
        bus.cdbValid <= 1'b1;
        bus.cdbRobId <= headData[ENTRY_W-1:32];
        bus.cdbVal   <= headData[31:0];
        bus.cdbSrc   <= grantIdx;
        rrPtr        <= grantIdx;
      end else begin
        bus.cdbValid <= 1'b0;
      end
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Survives clear so flushes do not hide backpressure history.
  logic [31:0] stallReg;

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn)
      stallReg <= '0;
    else if (|(bus.srcValid & ~bus.srcReady))
      stallReg <= stallReg + 32'd1;
  end

  assign bus.stallCount = stallReg;
`else
  assign bus.stallCount = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues checked against every CDB broadcast.
module tb_cdb_arbiter;
  localparam int NUM_SRC   = 3;
  localparam int SRC_WIDTH = 2;
  localparam int ROB_WIDTH = 4;
`ifdef CDB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clockIn;
  logic resetIn;
  logic clear;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .SRC_WIDTH(SRC_WIDTH), .ROB_WIDTH(ROB_WIDTH)) bus ();

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .SRC_WIDTH(SRC_WIDTH), .ROB_WIDTH(ROB_WIDTH)) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .clear   (clear),
    .bus     (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [35:0] expQ [NUM_SRC][$];
  int          seenSrc [$];
  int unsigned stallExp = 0;
  int          monSrc;
  logic [35:0] monExp;
  int          nSent [NUM_SRC];
  logic [NUM_SRC-1:0] accNow;

  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] stallWant();
    return STALL_EN ? 64'(stallExp) : 64'd0;
  endfunction

  task automatic setSrc(input int s, input logic [3:0] rob, input logic [31:0] val);
    bus.srcValid[s]          = 1'b1;
    bus.srcRobId[s*4 +: 4]   = rob;
    bus.srcVal[s*32 +: 32]   = val;
  endtask

  task automatic flushModel();
    for (int i = 0; i < NUM_SRC; i++) expQ[i].delete();
  endtask

  // Record accepted pushes and stalls for the coming edge, then step to just after it.
  task automatic driveCycle();
    logic [NUM_SRC-1:0] acc;
    acc = clear ? '0 : (bus.srcValid & bus.srcReady);
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) expQ[i].push_back({bus.srcRobId[i*4 +: 4], bus.srcVal[i*32 +: 32]});
    if (|(bus.srcValid & ~bus.srcReady)) stallExp++;
    @(posedge clockIn);
    #1;
    if (clear) flushModel();
  endtask

  always @(negedge clockIn) begin
    if (!resetIn && bus.cdbValid) begin
      monSrc = int'(bus.cdbSrc);
      seenSrc.push_back(monSrc);
      if (monSrc >= NUM_SRC) begin
        checkEq("cdb_src_range", 64'(monSrc), 64'(NUM_SRC - 1));
      end else begin
        checkEq("cdb_pending", 64'(expQ[monSrc].size() != 0), 64'd1);
        if (expQ[monSrc].size() != 0) begin
          monExp = expQ[monSrc].pop_front();
          checkEq("cdb_robid", 64'(bus.cdbRobId), 64'(monExp[35:32]));
          checkEq("cdb_val", 64'(bus.cdbVal), 64'(monExp[31:0]));
        end
      end
    end
  end

  initial begin
    resetIn      = 1'b1;
    clear        = 1'b0;
    bus.srcValid = '0;
    bus.srcRobId = '0;
    bus.srcVal   = '0;

    // Async reset visible before any clock edge
    #2;
    checkEq("rst_valid_noclk", 64'(bus.cdbValid), 64'd0);
    checkEq("rst_ready_noclk", 64'(bus.srcReady), 64'b111);
    checkEq("rst_stall_noclk", 64'(bus.stallCount), 64'd0);
    repeat (2) @(posedge clockIn);
    #1;
    resetIn = 1'b0;
    checkEq("rst_ready", 64'(bus.srcReady), 64'b111);
    checkEq("rst_valid", 64'(bus.cdbValid), 64'd0);
    checkEq("rst_robid", 64'(bus.cdbRobId), 64'd0);
    checkEq("rst_val", 64'(bus.cdbVal), 64'd0);
    checkEq("rst_src", 64'(bus.cdbSrc), 64'd0);

    // Single result latency
    setSrc(0, 4'd5, 32'h1234);
    driveCycle();
    bus.srcValid = '0;
    checkEq("t2_valid_k", 64'(bus.cdbValid), 64'd0);
    driveCycle();
    checkEq("t2_valid_k1", 64'(bus.cdbValid), 64'd1);
    checkEq("t2_robid_k1", 64'(bus.cdbRobId), 64'd5);
    checkEq("t2_val_k1", 64'(bus.cdbVal), 64'h1234);
    checkEq("t2_src_k1", 64'(bus.cdbSrc), 64'd0);
    driveCycle();
    checkEq("t2_valid_k2", 64'(bus.cdbValid), 64'd0);

    resetIn = 1'b1;
    #1;
    resetIn = 1'b0;
    flushModel();
    stallExp = 0;
    seenSrc.delete();

    // Simultaneous push from all sources
    setSrc(0, 4'd1, 32'h101);
    setSrc(1, 4'd2, 32'h202);
    setSrc(2, 4'd3, 32'h303);
    driveCycle();
    bus.srcValid = '0;
    repeat (4) driveCycle();
    checkEq("t3_count", 64'(seenSrc.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      checkEq($sformatf("t3_src%0d", i), 64'((i < seenSrc.size()) ? seenSrc[i] : 99), 64'(i));

    // Two sources streaming with backpressure
    seenSrc.delete();
    for (int s = 0; s < NUM_SRC; s++) nSent[s] = 0;
    for (int cyc = 0; cyc < 40 && (nSent[0] < 4 || nSent[1] < 4); cyc++) begin
      for (int s = 0; s < 2; s++) begin
        if (nSent[s] < 4) setSrc(s, 4'(s * 8 + nSent[s]), 32'hA000 + 32'(s * 16 + nSent[s]));
        else bus.srcValid[s] = 1'b0;
      end
      accNow = bus.srcValid & bus.srcReady;
      driveCycle();
      for (int s = 0; s < 2; s++) if (accNow[s]) nSent[s]++;
      if (cyc == 0) checkEq("t4_ready_e0", 64'(bus.srcReady), 64'b111);
      if (cyc == 1) checkEq("t4_ready_e1", 64'(bus.srcReady), 64'b101);
    end
    bus.srcValid = '0;
    repeat (6) driveCycle();
    checkEq("t4_sent0", 64'(nSent[0]), 64'd4);
    checkEq("t4_sent1", 64'(nSent[1]), 64'd4);
    checkEq("t4_count", 64'(seenSrc.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      checkEq($sformatf("t4_order%0d", i), 64'((i < seenSrc.size()) ? seenSrc[i] : 99), 64'(i % 2));
    checkEq("t4_stall", bus.stallCount, stallWant());

    // Clear with two results buffered in FIFO1
    seenSrc.delete();
    setSrc(0, 4'd6, 32'h606);
    setSrc(1, 4'd7, 32'h707);
    setSrc(2, 4'd8, 32'h808);
    driveCycle();
    bus.srcValid = '0;
    setSrc(1, 4'd9, 32'h909);
    driveCycle();
    bus.srcValid = '0;
    checkEq("t5_ready_full", 64'(bus.srcReady), 64'b101);
    clear = 1'b1;
    setSrc(0, 4'd11, 32'hB0B);
    driveCycle();
    clear = 1'b0;
    bus.srcValid = '0;
    checkEq("t5_valid_clr", 64'(bus.cdbValid), 64'd0);
    checkEq("t5_ready_clr", 64'(bus.srcReady), 64'b111);
    for (int i = 0; i < 3; i++) begin
      driveCycle();
      checkEq($sformatf("t5_idle%0d", i), 64'(bus.cdbValid), 64'd0);
    end
    checkEq("t5_seen", 64'(seenSrc.size()), 64'd1);
    checkEq("t5_stall_kept", bus.stallCount, stallWant());

    // Three sources streaming; backpressure counter
    for (int s = 0; s < NUM_SRC; s++) nSent[s] = 0;
    for (int cyc = 0; cyc < 40 && (nSent[0] < 3 || nSent[1] < 3 || nSent[2] < 3); cyc++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (nSent[s] < 3) setSrc(s, 4'(s * 4 + nSent[s]), 32'hC000 + 32'(s * 16 + nSent[s]));
        else bus.srcValid[s] = 1'b0;
      end
      accNow = bus.srcValid & bus.srcReady;
      driveCycle();
      for (int s = 0; s < NUM_SRC; s++) if (accNow[s]) nSent[s]++;
    end
    bus.srcValid = '0;
    repeat (8) driveCycle();
    for (int s = 0; s < NUM_SRC; s++) begin
      checkEq($sformatf("t6_sent%0d", s), 64'(nSent[s]), 64'd3);
      checkEq($sformatf("t6_drain%0d", s), 64'(expQ[s].size()), 64'd0);
    end
    checkEq("t6_stall", bus.stallCount, stallWant());
    clear = 1'b1;
    driveCycle();
    clear = 1'b0;
    checkEq("t6_stall_after_clr", bus.stallCount, stallWant());

    // Async reset while a broadcast is on the bus
    setSrc(0, 4'd12, 32'hBEEF);
    driveCycle();
    bus.srcValid = '0;
    driveCycle();
    checkEq("t7_valid_pre", 64'(bus.cdbValid), 64'd1);
    resetIn = 1'b1;
    #1;
    checkEq("t7_valid_rst", 64'(bus.cdbValid), 64'd0);
    checkEq("t7_robid_rst", 64'(bus.cdbRobId), 64'd0);
    checkEq("t7_val_rst", 64'(bus.cdbVal), 64'd0);
    checkEq("t7_src_rst", 64'(bus.cdbSrc), 64'd0);
    checkEq("t7_stall_rst", 64'(bus.stallCount), 64'd0);
    checkEq("t7_ready_rst", 64'(bus.srcReady), 64'b111);
    flushModel();
    stallExp = 0;
    #2;
    resetIn = 1'b0;
    repeat (3) driveCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
